cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- MIPS coprocessor-0 register file. Services the writeback stage's CP0 requests: MTC0/MFC0 access, exception entry, ERET return, and interrupt detection.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC, and runs the Count/Compare timer.
- Supplies the interrupt request and the ERET target (EPC) back to writeback, which uses them to flush the pipeline.

Parameters:
- COUNT_DIV, 2, clock cycles per Count increment; must be a power of two, minimum 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  writeback instruction valid and not flushed; qualifies every state update
- op_mtc0  in  1  MTC0 in writeback
- op_mfc0  in  1  MFC0 in writeback (read only, no state effect)
- op_eret  in  1  ERET in writeback
- op_sysc  in  1  SYSCALL flag; informational only, already folded into wb_ex/wb_excode
- wb_ex  in  1  exception taken this cycle
- wb_bd  in  1  excepting instruction sits in a delay slot
- ext_int_in  in  6  external hardware interrupt lines, level-sensitive
- wb_excode  in  5  exception code
- wb_pc  in  32  PC of the writeback instruction
- wb_badvaddr  in  32  faulting address for ADEL/ADES
- wb_rd  in  5  CP0 register number
- wb_sel  in  3  CP0 select
- c0_wdata  in  32  MTC0 write data
- has_int  out  1  pending enabled interrupt
- c0_rdata  out  32  read data; EPC while op_eret=1

Behaviour:
- Address map (rd,sel): BadVAddr (8,0), Count (9,0), Compare (11,0), Status (12,0), Cause (13,0), EPC (14,0). All other addresses read 0 and ignore writes.
- Reset values: Status=0x0040_0000 (BEV=1), Cause=0, Count=0, Compare=0, EPC=0, BadVAddr=0, tick counter=0. Resulting outputs: has_int=0; c0_rdata is a pure function of the address.

Status:
- Bit 22 BEV is read-only 1.
- IM[15:8], EXL bit 1 and IE bit 0 are writable.
- All other bits read 0.

Cause:
- BD bit 31 and TI bit 30 are read-only.
- IP[15:10] = {ext_int_in[5] | TI, ext_int_in[4:0]}, sampled into the register every cycle.
- IP[9:8] are software-writable.
- ExcCode[6:2] is read-only to software.
- All other bits are 0.

c0_rdata:
- Combinational from current register contents, so MFC0 has zero latency.
- op_eret=1 forces the EPC value.

Update priority per cycle, evaluated only when wb_valid=1: wb_ex > op_eret > op_mtc0.
- wb_ex:
  - If EXL was 0: EPC <= wb_bd ? wb_pc-4 : wb_pc, and Cause.BD <= wb_bd.
  - If EXL was 1: EPC and BD are unchanged.
  - Always: EXL <= 1 and ExcCode <= wb_excode.
  - If wb_excode is 0x04 (ADEL) or 0x05 (ADES): BadVAddr <= wb_badvaddr.
- op_eret: EXL <= 0. No other state changes.
- op_mtc0: write the addressed register, masked to its writable bits.

Timer:
- An internal tick counter wraps every COUNT_DIV cycles; Count increments by 1 on the wrap, with 32-bit wrap-around (0xFFFF_FFFF -> 0).
- An MTC0 to Count in the same cycle overrides the increment and resets the tick counter to 0.
- TI is set in the cycle after Count==Compare and stays set until an MTC0 to Compare clears it.
- An MTC0 to Compare in the same cycle as a match leaves TI cleared (the write wins).

has_int:
- has_int = |(Cause.IP[15:8] & Status.IM[15:8]) & Status.IE & ~Status.EXL.
- Derived from registers only, so there is no combinational path from the wb_* inputs.

Boundary cases:
- wb_valid=0: no architectural update. Count and TI still advance; IP sampling continues.
- Reset mid-operation restores all reset values on the next edge and clears pending TI.

Test Plan:
- Reset -> Status reads 0x0040_0000; Count, Compare, Cause and EPC read 0; has_int=0.
- MTC0 Compare=5 with COUNT_DIV=2 -> Count reaches 5 after 10 cycles and TI sets the following cycle. With Status=0x0000_8001, has_int rises. MTC0 Compare=5 again -> TI=0, has_int=0.
- Exception wb_ex=1, wb_excode=0x04, wb_pc=0xBFC0_0104, wb_bd=1, wb_badvaddr=0x1234_5671, EXL=0 -> next cycle EPC=0xBFC0_0100, Cause=0x8000_0010, BadVAddr=0x1234_5671, EXL=1, has_int=0.
- Nested exception while EXL=1 with wb_pc=0xBFC0_0200, excode 0x08 -> EPC unchanged, ExcCode=0x08.
- Then ERET -> c0_rdata equals EPC in the ERET cycle, and EXL=0 the next cycle.
- Simultaneous wb_ex=1 and op_mtc0 to EPC=0xDEAD_BEEF with wb_pc=0x100 -> EPC=0x100 (exception wins).
- Same case with wb_valid=0 -> no change.
- MTC0 Cause=0x0000_0300, Status=0x0000_0101 -> has_int=1 the next cycle. ext_int_in=6'b000001 with IM2 cleared -> IP2 visible in Cause, has_int unaffected.

Source files
------------

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: BadVAddr, Count/Compare timer, Status, Cause and EPC.
// Handles MTC0/MFC0, exception entry, ERET and interrupt-pending detection.
module cp0_regfile #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        op_mtc0,
  input  logic        op_mfc0,
  input  logic        op_eret,
  input  logic        op_sysc,
  input  logic        wb_ex,
  input  logic        wb_bd,
  input  logic [5:0]  ext_int_in,
  input  logic [4:0]  wb_excode,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badvaddr,
  input  logic [4:0]  wb_rd,
  input  logic [2:0]  wb_sel,
  input  logic [31:0] c0_wdata,
  output logic        has_int,
  output logic [31:0] c0_rdata
);

  localparam int TW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(COUNT_DIV - 1);

  logic [31:0]   badvaddr_q, badvaddr_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic [31:0]   epc_q, epc_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    im_q, im_d;
  logic          exl_q, exl_d;
  logic          ie_q, ie_d;
  logic          bd_q, bd_d;
  logic          ti_q, ti_d;
  logic [5:0]    ip_hw_q, ip_hw_d;
  logic [1:0]    ip_sw_q, ip_sw_d;
  logic [4:0]    exccode_q, exccode_d;

  logic [31:0] status_val, cause_val;
  logic        sel_badvaddr, sel_count, sel_compare, sel_status, sel_cause, sel_epc;
  logic        wr_en, tick_wrap;
  logic        unused_inputs;

  assign unused_inputs = op_mfc0 ^ op_sysc;

  assign sel_badvaddr = (wb_sel == 3'd0) && (wb_rd == 5'd8);
  assign sel_count    = (wb_sel == 3'd0) && (wb_rd == 5'd9);
  assign sel_compare  = (wb_sel == 3'd0) && (wb_rd == 5'd11);
  assign sel_status   = (wb_sel == 3'd0) && (wb_rd == 5'd12);
  assign sel_cause    = (wb_sel == 3'd0) && (wb_rd == 5'd13);
  assign sel_epc      = (wb_sel == 3'd0) && (wb_rd == 5'd14);

  assign wr_en     = wb_valid && op_mtc0 && !wb_ex && !op_eret;
  assign tick_wrap = (tick_q == TICK_LAST);

  assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_val  = {bd_q, ti_q, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    tick_d     = tick_wrap ? '0 : tick_q + 1'b1;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ti_d       = ti_q | (count_q == compare_q);
    ip_hw_d    = {ext_int_in[5] | ti_q, ext_int_in[4:0]};
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;

    if (tick_wrap) begin
      count_d = count_q + 32'd1;
    end

    // Timer runs regardless of wb_valid; exception entry outranks ERET, which outranks MTC0.
    if (wb_valid) begin
      if (wb_ex) begin
        if (!exl_q) begin
          epc_d = wb_bd ? wb_pc - 32'd4 : wb_pc;
          bd_d  = wb_bd;
        end
        exl_d     = 1'b1;
        exccode_d = wb_excode;
        if (wb_excode == 5'h04 || wb_excode == 5'h05) begin
          badvaddr_d = wb_badvaddr;
        end
      end else if (op_eret) begin
        exl_d = 1'b0;
      end else if (op_mtc0) begin
        if (sel_count) begin
          count_d = c0_wdata;
          tick_d  = '0;
        end
        if (sel_compare) begin
          compare_d = c0_wdata;
          ti_d      = 1'b0;
        end
        if (sel_status) begin
          im_d  = c0_wdata[15:8];
          exl_d = c0_wdata[1];
          ie_d  = c0_wdata[0];
        end
        if (sel_cause) begin
          ip_sw_d = c0_wdata[9:8];
        end
        if (sel_epc) begin
          epc_d = c0_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      tick_q     <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      tick_q     <= tick_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
    end
  end

  // BadVAddr is read-only to software, so it has no MTC0 path above.
  always_comb begin
    c0_rdata = 32'b0;
    if (op_eret) begin
      c0_rdata = epc_q;
    end else if (sel_badvaddr) begin
      c0_rdata = badvaddr_q;
    end else if (sel_count) begin
      c0_rdata = count_q;
    end else if (sel_compare) begin
      c0_rdata = compare_q;
    end else if (sel_status) begin
      c0_rdata = status_val;
    end else if (sel_cause) begin
      c0_rdata = cause_val;
    end else if (sel_epc) begin
      c0_rdata = epc_q;
    end
  end

  assign has_int = (|({ip_hw_q, ip_sw_q} & im_q)) & ie_q & ~exl_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile; expectations are queued when
// stimulus is driven and compared after the clock edge that produces them.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, op_mtc0, op_mfc0, op_eret, op_sysc, wb_ex, wb_bd;
  logic [5:0]  ext_int_in;
  logic [4:0]  wb_excode, wb_rd;
  logic [2:0]  wb_sel;
  logic [31:0] wb_pc, wb_badvaddr, c0_wdata;
  logic        has_int;
  logic [31:0] c0_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        is_int;
    logic [4:0]  rd;
    logic [2:0]  sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  cp0_regfile #(.COUNT_DIV(2)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .op_mtc0(op_mtc0),
    .op_mfc0(op_mfc0), .op_eret(op_eret), .op_sysc(op_sysc), .wb_ex(wb_ex),
    .wb_bd(wb_bd), .ext_int_in(ext_int_in), .wb_excode(wb_excode),
    .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .wb_rd(wb_rd), .wb_sel(wb_sel),
    .c0_wdata(c0_wdata), .has_int(has_int), .c0_rdata(c0_rdata)
  );

  always #10 clk = ~clk;

  task automatic expect_reg(input string tag, input logic [4:0] rd, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.is_int = 1'b0; e.rd = rd; e.sel = 3'd0; e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_addr(input string tag, input logic [4:0] rd, input logic [2:0] sel,
                             input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.is_int = 1'b0; e.rd = rd; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic expect_int(input string tag, input logic val);
    exp_t e;
    e.tag = tag; e.is_int = 1'b1; e.rd = 5'd0; e.sel = 3'd0; e.val = {31'b0, val};
    sb.push_back(e);
  endtask

  task automatic set_mtc0(input logic [4:0] rd, input logic [2:0] sel, input logic [31:0] data);
    wb_valid = 1'b1; op_mtc0 = 1'b1; wb_rd = rd; wb_sel = sel; c0_wdata = data;
  endtask

  task automatic set_ex(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                        input logic [31:0] bad);
    wb_valid = 1'b1; wb_ex = 1'b1; wb_excode = code; wb_pc = pc; wb_bd = bd; wb_badvaddr = bad;
  endtask

  // One clock edge, then return the writeback controls to idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    wb_valid = 1'b0; op_mtc0 = 1'b0; op_mfc0 = 1'b0; op_eret = 1'b0;
    op_sysc = 1'b0; wb_ex = 1'b0; wb_bd = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.is_int) begin
        wb_rd = e.rd; wb_sel = e.sel;
        #1;
        obs = c0_rdata;
      end else begin
        #1;
        obs = {31'b0, has_int};
      end
      checks++;
      assert (obs === e.val) else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    reset = 1'b1; wb_valid = 0; op_mtc0 = 0; op_mfc0 = 0; op_eret = 0; op_sysc = 0;
    wb_ex = 0; wb_bd = 0; ext_int_in = '0; wb_excode = '0; wb_pc = '0;
    wb_badvaddr = '0; wb_rd = '0; wb_sel = '0; c0_wdata = '0;

    repeat (2) @(posedge clk);
    expect_reg("rst_status", 5'd12, 32'h0040_0000);
    expect_reg("rst_count", 5'd9, 32'h0);
    expect_reg("rst_compare", 5'd11, 32'h0);
    expect_reg("rst_cause", 5'd13, 32'h0);
    expect_reg("rst_epc", 5'd14, 32'h0);
    expect_int("rst_has_int", 1'b0);
    applyStimulus();
    checkOutput();

    // Timer: Compare=5, restart Count at 0, watch TI and then IP7 arrive.
    reset = 1'b0;
    set_mtc0(5'd12, 3'd0, 32'h0000_8001);
    applyStimulus();
    set_mtc0(5'd11, 3'd0, 32'd5);
    applyStimulus();
    set_mtc0(5'd9, 3'd0, 32'd0);
    applyStimulus();
    repeat (9) applyStimulus();
    expect_reg("count_at_5", 5'd9, 32'd5);
    expect_reg("cause_before_ti", 5'd13, 32'h0);
    expect_int("int_before_ti", 1'b0);
    applyStimulus();
    checkOutput();
    expect_reg("cause_ti_set", 5'd13, 32'h4000_0000);
    expect_int("int_ip_lag", 1'b0);
    applyStimulus();
    checkOutput();
    expect_reg("cause_ti_ip7", 5'd13, 32'h4000_8000);
    expect_int("int_timer", 1'b1);
    expect_reg("count_at_6", 5'd9, 32'd6);
    applyStimulus();
    checkOutput();
    set_mtc0(5'd11, 3'd0, 32'd5);
    expect_reg("cause_ti_cleared", 5'd13, 32'h0000_8000);
    applyStimulus();
    checkOutput();
    expect_reg("cause_ip7_cleared", 5'd13, 32'h0);
    expect_int("int_timer_off", 1'b0);
    applyStimulus();
    checkOutput();

    // Exception in a delay slot with EXL=0.
    set_ex(5'h04, 32'hBFC0_0104, 1'b1, 32'h1234_5671);
    expect_reg("ex_epc", 5'd14, 32'hBFC0_0100);
    expect_reg("ex_cause", 5'd13, 32'h8000_0010);
    expect_reg("ex_badvaddr", 5'd8, 32'h1234_5671);
    expect_reg("ex_status", 5'd12, 32'h0040_8003);
    expect_int("ex_has_int", 1'b0);
    applyStimulus();
    checkOutput();

    // Nested exception keeps EPC/BD and BadVAddr.
    set_ex(5'h08, 32'hBFC0_0200, 1'b0, 32'hAAAA_AAAA);
    expect_reg("nest_epc", 5'd14, 32'hBFC0_0100);
    expect_reg("nest_cause", 5'd13, 32'h8000_0020);
    expect_reg("nest_badvaddr", 5'd8, 32'h1234_5671);
    applyStimulus();
    checkOutput();

    // ERET exposes EPC combinationally, then clears EXL.
    wb_valid = 1'b1; op_eret = 1'b1;
    expect_reg("eret_rdata", 5'd12, 32'hBFC0_0100);
    checkOutput();
    expect_reg("eret_status", 5'd12, 32'h0040_8001);
    applyStimulus();
    checkOutput();

    // Exception outranks a simultaneous MTC0 to EPC.
    set_ex(5'h08, 32'h0000_0100, 1'b0, 32'h0);
    op_mtc0 = 1'b1; wb_rd = 5'd14; wb_sel = 3'd0; c0_wdata = 32'hDEAD_BEEF;
    expect_reg("prio_epc", 5'd14, 32'h0000_0100);
    expect_reg("prio_cause", 5'd13, 32'h0000_0020);
    expect_reg("prio_status", 5'd12, 32'h0040_8003);
    applyStimulus();
    checkOutput();

    set_ex(5'h08, 32'h0000_0200, 1'b0, 32'h0);
    wb_valid = 1'b0;
    op_mtc0 = 1'b1; wb_rd = 5'd14; wb_sel = 3'd0; c0_wdata = 32'hDEAD_BEEF;
    expect_reg("novalid_epc", 5'd14, 32'h0000_0100);
    expect_reg("novalid_status", 5'd12, 32'h0040_8003);
    applyStimulus();
    checkOutput();

    // Unmapped selects read zero and ignore writes.
    set_mtc0(5'd12, 3'd1, 32'h0000_0000);
    expect_reg("unmapped_status_kept", 5'd12, 32'h0040_8003);
    expect_addr("unmapped_read_sel1", 5'd12, 3'd1, 32'h0);
    expect_addr("unmapped_read_rd0", 5'd0, 3'd0, 32'h0);
    applyStimulus();
    checkOutput();

    // Software interrupts, then an external line whose mask is clear.
    set_mtc0(5'd13, 3'd0, 32'h0000_0300);
    applyStimulus();
    set_mtc0(5'd12, 3'd0, 32'h0000_0101);
    expect_int("sw_int", 1'b1);
    expect_reg("sw_cause", 5'd13, 32'h0000_0320);
    expect_reg("sw_status", 5'd12, 32'h0040_0101);
    applyStimulus();
    checkOutput();
    set_mtc0(5'd13, 3'd0, 32'h0000_0000);
    ext_int_in = 6'b000001;
    expect_reg("ext_ip2", 5'd13, 32'h0000_0420);
    expect_int("ext_masked", 1'b0);
    applyStimulus();
    checkOutput();

    // Count wraps from all-ones to zero.
    set_mtc0(5'd9, 3'd0, 32'hFFFF_FFFF);
    applyStimulus();
    expect_reg("count_ffff", 5'd9, 32'hFFFF_FFFF);
    applyStimulus();
    checkOutput();
    expect_reg("count_wrap", 5'd9, 32'h0);
    applyStimulus();
    checkOutput();

    // Reset in the middle of operation.
    reset = 1'b1;
    ext_int_in = '0;
    expect_reg("mid_rst_status", 5'd12, 32'h0040_0000);
    expect_reg("mid_rst_cause", 5'd13, 32'h0);
    expect_reg("mid_rst_count", 5'd9, 32'h0);
    expect_reg("mid_rst_epc", 5'd14, 32'h0);
    expect_reg("mid_rst_badvaddr", 5'd8, 32'h0);
    expect_int("mid_rst_has_int", 1'b0);
    applyStimulus();
    checkOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
